parking_ctrl_n: RTL and testbench
=================================

Name: parking_ctrl_n

Overview:
Parametrised parking-lot controller. Tracks occupancy of N_SLOTS numbered spaces and assigns each entering car the lowest-numbered free slot. Frees a slot on exit and drives a timed door. Successor to the fixed 4-slot parking circuit; adds edge-detected requests, simultaneous enter/exit, error reporting, a lock mode and a programmable door timer. Sits between the gate sensors and switches and the display/LED logic.

Parameters:
N_SLOTS, 4, number of parking slots (2..64).
DOOR_CYCLES, 3, clock cycles door_open stays high after an accepted event (>=1).
IDX_W, $clog2(N_SLOTS), slot index width (derived localparam).
CNT_W, $clog2(N_SLOTS+1), free-count width (derived localparam).

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
enter  input  1  entry sensor (level); a rising edge is an entry request.
exit  input  1  exit sensor (level); a rising edge is an exit request.
switch  input  IDX_W  slot index being vacated; sampled on the cycle the exit edge is detected.
lock  input  1  high = entries refused, exits still served.
full  output  1  no free slots.
empty  output  1  no occupied slots.
door_open  output  1  door drive.
capacity  output  CNT_W  number of free slots.
L  output  IDX_W  slot assigned by the most recent accepted entry.
F  output  N_SLOTS  occupied bitmap; bit i = slot i taken.
E  output  N_SLOTS  free bitmap; always equals ~F.
grant  output  1  one-cycle pulse: entry accepted.
err  output  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (RST=1 at a clock edge):
  - F=0, E=all ones, capacity=N_SLOTS, full=0, empty=1.
  - door_open=0, L=0, grant=0, err=0.
  - Door counter=0, FSM=IDLE, edge registers enter_q/exit_q=0.
  - Reset mid-door or mid-request aborts everything.
  - An input still high after RST falls produces one edge on the first post-reset cycle.
- Edge detection:
  - en_ev = enter & ~enter_q; ex_ev = exit & ~exit_q. enter_q/exit_q are registered every cycle.
  - Holding a level high produces exactly one request.
- Latency: the request is evaluated combinationally in the detection cycle. F, E, capacity, full, empty, L, grant, err and door_open all reflect it one clock edge later.
- Exit evaluation (first):
  - Valid iff ex_ev, switch < N_SLOTS, and F[switch]=1.
  - Valid exit clears F[switch].
  - Invalid exit: err=1, no state change, no door.
- Entry evaluation (second), against the bitmap after the exit is applied:
  - Accepted iff en_ev, lock=0, and at least one slot is free.
  - Accepted entry sets the lowest-index free bit, L=that index, grant=1.
  - Otherwise err=1; L and F are unchanged.
- Simultaneous valid exit + entry while full: the entry takes the lowest free slot (possibly the one just freed). Capacity is unchanged and grant=1.
- Simultaneous invalid exit + rejected entry: err=1 (single pulse).
- Derived outputs:
  - capacity = N_SLOTS - popcount(F).
  - full = (capacity==0); empty = (capacity==N_SLOTS).
  - All are registered; F and capacity are never inconsistent.
- Door FSM:
  - IDLE -> OPEN on any accepted entry or valid exit; counter loaded with DOOR_CYCLES.
  - In OPEN, door_open=1 and the counter decrements each cycle. OPEN -> IDLE when the counter reaches 1 and no new accepted event occurs.
  - A new accepted event in OPEN reloads the counter to DOOR_CYCLES.
  - Rejected requests never open or extend the door.
  - door_open is high for exactly DOOR_CYCLES cycles after an isolated event.
- lock may change on any cycle. It affects only entries evaluated in the same cycle.
- grant and err are never high for more than one cycle per request.

Test Plan (N_SLOTS=4, DOOR_CYCLES=3):
1. Reset, then 4 separate enter pulses -> L=0,1,2,3 in turn, capacity 4->3->2->1->0, F=1111, full=1 after the 4th, door_open high 3 cycles after each.
2. Full lot, 5th enter pulse -> err=1 for one cycle, F/L/capacity unchanged, door_open stays 0.
3. Full lot, switch=3 with exit pulse, then switch=2 with exit pulse -> F=0111 then 0011, capacity=2; next enter -> L=2, F=0111.
4. F=0011, exit with switch=3 (empty slot) -> err pulse, F unchanged; with N_SLOTS=5 and switch=7 -> err, no change.
5. Full lot, enter and exit (switch=1) edges in the same cycle -> grant=1, L=1, F=1111, capacity=0, single door opening of 3 cycles.
6. lock=1 with enter pulse -> err, no change; enter held high 20 cycles with lock=0 -> exactly one grant. Assert RST while door_open=1 -> next cycle door_open=0, F=0, capacity=4.

Source files
------------

// File: rtl/parking_ctrl_n.sv
// Parking-lot controller: per-slot occupancy bitmap, lowest-free-slot assignment,
// edge-detected enter/exit requests, entry lock and a retriggerable door timer.
module parking_ctrl_n #(
    parameter  int N_SLOTS     = 4,
    parameter  int DOOR_CYCLES = 3,
    localparam int IDX_W       = $clog2(N_SLOTS),
    localparam int CNT_W       = $clog2(N_SLOTS + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enter,
    input  logic               exit,
    input  logic [IDX_W-1:0]   switch,
    input  logic               lock,
    output logic               full,
    output logic               empty,
    output logic               door_open,
    output logic [CNT_W-1:0]   capacity,
    output logic [IDX_W-1:0]   L,
    output logic [N_SLOTS-1:0] F,
    output logic [N_SLOTS-1:0] E,
    output logic               grant,
    output logic               err
);
    localparam int PAD_W = 1 << IDX_W;
    localparam int DC_W  = $clog2(DOOR_CYCLES + 1);

    typedef enum logic {IDLE, OPEN} door_state_t;

    door_state_t        state_reg;
    logic [DC_W-1:0]    door_cnt_reg;
    logic               enter_q, exit_q;
    logic [N_SLOTS-1:0] f_reg;
    logic [CNT_W-1:0]   cap_reg;
    logic               full_reg, empty_reg, door_reg, grant_reg, err_reg;
    logic [IDX_W-1:0]   l_reg;

    logic               en_ev, ex_ev, exit_ok, entry_ok, any_free, accepted, err_next;
    logic [PAD_W-1:0]   f_pad;
    logic [N_SLOTS-1:0] f_exit, f_next;
    logic [IDX_W-1:0]   free_idx;
    logic [CNT_W-1:0]   used_cnt, cap_next;

    assign en_ev = enter & ~enter_q;
    assign ex_ev = exit & ~exit_q;

    // Padding the bitmap to a power of two makes out-of-range slot numbers read as free,
    // so an exit for a nonexistent slot is rejected without a separate range compare.
    assign f_pad   = PAD_W'(f_reg);
    assign exit_ok = ex_ev & f_pad[switch];

    always_comb begin
        f_exit = f_reg;
        if (exit_ok)
            f_exit = f_reg & ~(N_SLOTS'(1) << switch);
    end

    // Entry is evaluated against the bitmap after the exit, so a freed slot is reusable at once.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!f_exit[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign entry_ok = en_ev & ~lock & any_free;
    assign accepted = entry_ok | exit_ok;
    assign err_next = (ex_ev & ~exit_ok) | (en_ev & ~entry_ok);

    always_comb begin
        f_next = f_exit;
        if (entry_ok)
            f_next = f_exit | (N_SLOTS'(1) << free_idx);
    end

    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++)
            used_cnt = used_cnt + CNT_W'(f_next[i]);
    end

    assign cap_next = CNT_W'(N_SLOTS) - used_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            door_cnt_reg <= '0;
            door_reg     <= 1'b0;
            enter_q      <= 1'b0;
            exit_q       <= 1'b0;
            f_reg        <= '0;
            cap_reg      <= CNT_W'(N_SLOTS);
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            l_reg        <= '0;
            grant_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            enter_q   <= enter;
            exit_q    <= exit;
            f_reg     <= f_next;
            cap_reg   <= cap_next;
            full_reg  <= (cap_next == '0);
            empty_reg <= (cap_next == CNT_W'(N_SLOTS));
            grant_reg <= entry_ok;
            err_reg   <= err_next;
            if (entry_ok)
                l_reg <= free_idx;

            case (state_reg)
                IDLE: begin
                    if (accepted) begin
                        state_reg    <= OPEN;
                        door_cnt_reg <= DC_W'(DOOR_CYCLES);
                        door_reg     <= 1'b1;
                    end
                end
                OPEN: begin
                    if (accepted) begin
                        door_cnt_reg <= DC_W'(DOOR_CYCLES);
                    end else if (door_cnt_reg == DC_W'(1)) begin
                        state_reg    <= IDLE;
                        door_cnt_reg <= '0;
                        door_reg     <= 1'b0;
                    end else begin
                        door_cnt_reg <= door_cnt_reg - DC_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    door_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign F         = f_reg;
    assign E         = ~f_reg;
    assign capacity  = cap_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign L         = l_reg;
    assign grant     = grant_reg;
    assign err       = err_reg;
    assign door_open = door_reg;

endmodule

// File: tb/tb_parking_ctrl_n.sv
// Scoreboard bench for parking_ctrl_n: a 4-slot lot for the main sequence and a
// 5-slot lot for out-of-range exit slot numbers.
module tb_parking_ctrl_n;
    typedef struct packed {
        logic       g;
        logic       e;
        logic [2:0] l;
        logic [7:0] f;
        logic [3:0] cap;
        logic       full;
        logic       empty;
        logic       door;
    } rec_t;

    logic CLK;
    logic rst4, en4, ex4, lk4;
    logic [1:0] sw4;
    logic full4, empty4, door4, grant4, err4;
    logic [2:0] cap4;
    logic [1:0] l4;
    logic [3:0] f4, e4;

    logic rst5, en5, ex5, lk5;
    logic [2:0] sw5;
    logic full5, empty5, door5, grant5, err5;
    logic [2:0] cap5;
    logic [2:0] l5;
    logic [4:0] f5, e5;

    int total = 0;
    int bad   = 0;
    rec_t sb4[$];
    rec_t sb5[$];
    int   dq4[$];

    parking_ctrl_n #(.N_SLOTS(4), .DOOR_CYCLES(3)) dut4 (
        .CLK(CLK), .RST(rst4), .enter(en4), .exit(ex4), .switch(sw4), .lock(lk4),
        .full(full4), .empty(empty4), .door_open(door4), .capacity(cap4),
        .L(l4), .F(f4), .E(e4), .grant(grant4), .err(err4)
    );

    parking_ctrl_n #(.N_SLOTS(5), .DOOR_CYCLES(3)) dut5 (
        .CLK(CLK), .RST(rst5), .enter(en5), .exit(ex5), .switch(sw5), .lock(lk5),
        .full(full5), .empty(empty5), .door_open(door5), .capacity(cap5),
        .L(l5), .F(f5), .E(e5), .grant(grant5), .err(err5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic rec_t mk(input logic g, input logic e, input logic [2:0] l,
                                input logic [7:0] f, input logic [3:0] c,
                                input logic fu, input logic em, input logic dr);
        return {g, e, l, f, c, fu, em, dr};
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("grant=%0d err=%0d L=%0d F=%b cap=%0d full=%0d empty=%0d door=%0d",
                         r.g, r.e, r.l, r.f, r.cap, r.full, r.empty, r.door);
    endfunction

    task automatic chk(input string tag, input rec_t x, input rec_t a);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %s, expected %s", tag, fmt(a), fmt(x));
        end else begin
            $display("ok   %s: %s", tag, fmt(a));
        end
    endtask

    task automatic take4(input string tag, input rec_t a);
        if (sb4.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: unexpected response %s, expected none", tag, fmt(a));
        end else begin
            chk(tag, sb4.pop_front(), a);
        end
    endtask

    task automatic take5(input string tag, input rec_t a);
        if (sb5.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: unexpected response %s, expected none", tag, fmt(a));
        end else begin
            chk(tag, sb5.pop_front(), a);
        end
    endtask

    // Response monitor, 4-slot lot: a reset, a grant/err pulse or a bitmap change is one response.
    initial begin
        logic armed;
        logic [3:0] fprev;
        rec_t act;
        int n;
        armed = 1'b1; fprev = '0; n = 0;
        forever begin
            @(posedge CLK); #1;
            act = {grant4, err4, 3'(l4), 8'(f4), 4'(cap4), full4, empty4, door4};
            if (rst4) begin
                if (armed) begin
                    armed = 1'b0;
                    take4($sformatf("reset4#%0d", n), act);
                    n++;
                end
            end else begin
                armed = 1'b1;
                if (grant4 === 1'b1 || err4 === 1'b1 || f4 !== fprev) begin
                    take4($sformatf("resp4#%0d", n), act);
                    n++;
                    total++;
                    if (e4 !== ~f4) begin
                        bad++;
                        $display("FAIL e_inv4: got E=%b, expected %b", e4, ~f4);
                    end
                end
            end
            fprev = f4;
        end
    end

    // Door-pulse monitor, 4-slot lot: each completed pulse is compared to its expected length.
    initial begin
        int dlen;
        int exp_len;
        dlen = 0;
        forever begin
            @(posedge CLK); #1;
            if (door4 === 1'b1) begin
                dlen++;
            end else if (dlen > 0) begin
                total++;
                if (dq4.size() == 0) begin
                    bad++;
                    $display("FAIL door4: got pulse of %0d cycles, expected none", dlen);
                end else begin
                    exp_len = dq4.pop_front();
                    if (dlen != exp_len) begin
                        bad++;
                        $display("FAIL door4: got pulse of %0d cycles, expected %0d", dlen, exp_len);
                    end else begin
                        $display("ok   door4: pulse of %0d cycles", dlen);
                    end
                end
                dlen = 0;
            end
        end
    end

    // Response monitor, 5-slot lot.
    initial begin
        logic armed;
        logic [4:0] fprev;
        rec_t act;
        int n;
        armed = 1'b1; fprev = '0; n = 0;
        forever begin
            @(posedge CLK); #1;
            act = {grant5, err5, l5, 8'(f5), 4'(cap5), full5, empty5, door5};
            if (rst5) begin
                if (armed) begin
                    armed = 1'b0;
                    take5($sformatf("reset5#%0d", n), act);
                    n++;
                end
            end else begin
                armed = 1'b1;
                if (grant5 === 1'b1 || err5 === 1'b1 || f5 !== fprev) begin
                    take5($sformatf("resp5#%0d", n), act);
                    n++;
                end
            end
            fprev = f5;
        end
    end

    task automatic req4(input logic en, input logic ex, input logic [1:0] sw,
                        input logic lk, input rec_t r, input int dl);
        @(negedge CLK);
        sb4.push_back(r);
        if (dl > 0) dq4.push_back(dl);
        en4 = en; ex4 = ex; sw4 = sw; lk4 = lk;
        @(negedge CLK);
        en4 = 1'b0; ex4 = 1'b0; lk4 = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic req5(input logic en, input logic ex, input logic [2:0] sw, input rec_t r);
        @(negedge CLK);
        sb5.push_back(r);
        en5 = en; ex5 = ex; sw5 = sw;
        @(negedge CLK);
        en5 = 1'b0; ex5 = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        rst4 = 1'b1; en4 = 1'b0; ex4 = 1'b0; sw4 = '0; lk4 = 1'b0;
        rst5 = 1'b1; en5 = 1'b0; ex5 = 1'b0; sw5 = '0; lk5 = 1'b0;
        sb4.push_back(mk(0, 0, 3'd0, 8'b0000, 4'd4, 0, 1, 0));
        sb5.push_back(mk(0, 0, 3'd0, 8'b00000, 4'd5, 0, 1, 0));
        repeat (2) @(negedge CLK);
        rst4 = 1'b0; rst5 = 1'b0;
        repeat (2) @(negedge CLK);

        // Fill the lot slot by slot
        req4(1, 0, 2'd0, 0, mk(1, 0, 3'd0, 8'b0001, 4'd3, 0, 0, 1), 3);
        req4(1, 0, 2'd0, 0, mk(1, 0, 3'd1, 8'b0011, 4'd2, 0, 0, 1), 3);
        req4(1, 0, 2'd0, 0, mk(1, 0, 3'd2, 8'b0111, 4'd1, 0, 0, 1), 3);
        req4(1, 0, 2'd0, 0, mk(1, 0, 3'd3, 8'b1111, 4'd0, 1, 0, 1), 3);
        // Entry into a full lot
        req4(1, 0, 2'd0, 0, mk(0, 1, 3'd3, 8'b1111, 4'd0, 1, 0, 0), 0);
        // Exits then re-entry takes the lowest free slot
        req4(0, 1, 2'd3, 0, mk(0, 0, 3'd3, 8'b0111, 4'd1, 0, 0, 1), 3);
        req4(0, 1, 2'd2, 0, mk(0, 0, 3'd3, 8'b0011, 4'd2, 0, 0, 1), 3);
        req4(1, 0, 2'd0, 0, mk(1, 0, 3'd2, 8'b0111, 4'd1, 0, 0, 1), 3);
        // Exit from an empty slot
        req4(0, 1, 2'd3, 0, mk(0, 1, 3'd2, 8'b0111, 4'd1, 0, 0, 0), 0);
        // Refill, then simultaneous exit + entry on a full lot
        req4(1, 0, 2'd0, 0, mk(1, 0, 3'd3, 8'b1111, 4'd0, 1, 0, 1), 3);
        req4(1, 1, 2'd1, 0, mk(1, 0, 3'd1, 8'b1111, 4'd0, 1, 0, 1), 3);
        req4(0, 1, 2'd1, 0, mk(0, 0, 3'd1, 8'b1101, 4'd1, 0, 0, 1), 3);
        // Invalid exit together with a locked entry: a single err pulse
        req4(1, 1, 2'd1, 1, mk(0, 1, 3'd1, 8'b1101, 4'd1, 0, 0, 0), 0);
        // Locked entry alone
        req4(1, 0, 2'd0, 1, mk(0, 1, 3'd1, 8'b1101, 4'd1, 0, 0, 0), 0);

        // Enter held high for 20 cycles yields one grant
        @(negedge CLK);
        sb4.push_back(mk(1, 0, 3'd1, 8'b1111, 4'd0, 1, 0, 1));
        dq4.push_back(3);
        en4 = 1'b1;
        repeat (20) @(negedge CLK);
        en4 = 1'b0;
        repeat (2) @(negedge CLK);

        req4(0, 1, 2'd0, 0, mk(0, 0, 3'd1, 8'b1110, 4'd1, 0, 0, 1), 3);

        // Reset one cycle into a door opening; enter stays high across reset release
        @(negedge CLK);
        sb4.push_back(mk(1, 0, 3'd0, 8'b1111, 4'd0, 1, 0, 1));
        dq4.push_back(1);
        en4 = 1'b1;
        @(negedge CLK);
        sb4.push_back(mk(0, 0, 3'd0, 8'b0000, 4'd4, 0, 1, 0));
        rst4 = 1'b1;
        @(negedge CLK);
        sb4.push_back(mk(1, 0, 3'd0, 8'b0001, 4'd3, 0, 0, 1));
        dq4.push_back(3);
        rst4 = 1'b0;
        repeat (3) @(negedge CLK);
        en4 = 1'b0;
        repeat (4) @(negedge CLK);

        // 5-slot lot: slot numbers at and beyond N_SLOTS are rejected
        req5(1, 0, 3'd0, mk(1, 0, 3'd0, 8'b00001, 4'd4, 0, 0, 1));
        req5(1, 0, 3'd0, mk(1, 0, 3'd1, 8'b00011, 4'd3, 0, 0, 1));
        req5(0, 1, 3'd7, mk(0, 1, 3'd1, 8'b00011, 4'd3, 0, 0, 0));
        req5(0, 1, 3'd5, mk(0, 1, 3'd1, 8'b00011, 4'd3, 0, 0, 0));
        req5(0, 1, 3'd4, mk(0, 1, 3'd1, 8'b00011, 4'd3, 0, 0, 0));

        repeat (10) @(negedge CLK);
        total++;
        if (sb4.size() != 0) begin
            bad++;
            $display("FAIL drain4: got %0d responses outstanding, expected 0", sb4.size());
        end
        total++;
        if (dq4.size() != 0) begin
            bad++;
            $display("FAIL door_drain4: got %0d door pulses outstanding, expected 0", dq4.size());
        end
        total++;
        if (sb5.size() != 0) begin
            bad++;
            $display("FAIL drain5: got %0d responses outstanding, expected 0", sb5.size());
        end
        total++;
        if (door4 !== 1'b0) begin
            bad++;
            $display("FAIL door_idle4: got door_open=%b, expected 0", door4);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
